// File: rtl/supernova_pkg.sv
// Shared types and constants for the supernova MDU issue path.
// - MDU_RS_DEPTH    : default number of reservation-station slots
// - rs_entry_t      : one reservation-station entry (operands, tags, ready bits)
// - rs_wakeup()     : applies one CDB broadcast to an entry
package supernova_pkg;

  localparam int XLEN          = 32;
  localparam int GPR_TAG_WIDTH = 6;
  localparam int ROB_IDX_WIDTH = 5;
  localparam int MDU_RS_DEPTH  = 4;

  typedef struct packed {
    logic [31:0]              instr;
    logic [XLEN-1:0]          src1_data;
    logic [XLEN-1:0]          src2_data;
    logic [GPR_TAG_WIDTH-1:0] src1_tag;
    logic [GPR_TAG_WIDTH-1:0] src2_tag;
    logic                     src1_ready;
    logic                     src2_ready;
    logic [GPR_TAG_WIDTH-1:0] rd_phys_tag;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
  } rs_entry_t;

  // Capture a CDB result into any still-waiting operand whose tag matches.
  // Tag 0 is x0 and is never woken by the CDB.
  function automatic rs_entry_t rs_wakeup(
    input rs_entry_t                e,
    input logic                     cdb_valid,
    input logic [GPR_TAG_WIDTH-1:0] cdb_tag,
    input logic [XLEN-1:0]          cdb_data
  );
    rs_entry_t r;
    logic      hit;
    r   = e;
    hit = cdb_valid && (cdb_tag != {GPR_TAG_WIDTH{1'b0}});
    if (hit && !e.src1_ready && (e.src1_tag == cdb_tag)) begin
      r.src1_ready = 1'b1;
      r.src1_data  = cdb_data;
    end else begin
      r.src1_ready = e.src1_ready;
    end
    if (hit && !e.src2_ready && (e.src2_tag == cdb_tag)) begin
      r.src2_ready = 1'b1;
      r.src2_data  = cdb_data;
    end else begin
      r.src2_ready = e.src2_ready;
    end
    return r;
  endfunction

endpackage

// File: rtl/supernova_oldest_ready_picker.sv
// Lowest-index priority picker over a ready vector.
// - ready_vec  in  : one bit per slot, slot 0 is oldest
// - grant_oh   out : one-hot of the lowest set bit (all zero if none)
// - grant_idx  out : binary index of the lowest set bit (0 if none)
// - any_ready  out : at least one bit of ready_vec is set
module supernova_oldest_ready_picker #(
  parameter  int DEPTH = 4,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] ready_vec,
  output logic [DEPTH-1:0] grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_ready
);

  // Isolate the lowest set bit (two's-complement trick) and encode its index.
  always_comb begin
    grant_oh  = ready_vec & (~ready_vec + {{(DEPTH-1){1'b0}}, 1'b1});
    any_ready = |ready_vec;
    grant_idx = {IDX_W{1'b0}};
    // Walk from the top down so the lowest ready index is the last one written.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      grant_idx = ready_vec[i] ? IDX_W'(i) : grant_idx;
    end
  end

endmodule

// File: rtl/supernova_mdu_issue_queue.sv
// Reservation station in front of the MDU: a collapsing queue (slot 0 oldest)
// that snoops the CDB and issues the oldest fully-ready entry.
// - clk, rst_n                          : clock, async active-low reset
// - disp_valid_in / disp_entry_in       : dispatch offer
// - disp_ready_out                      : a slot is free (registered count < DEPTH)
// - cdb_valid_in / cdb_tag_in / cdb_data_in : result broadcast for wakeup
// - flush_in                            : discard all entries on the next edge
// - issue_valid_out / issue_entry_out   : request to the MDU (from registered slots)
// - issue_ready_in                      : MDU accepts the presented entry
// - count_out                           : current occupancy
module supernova_mdu_issue_queue
  import supernova_pkg::*;
#(
  parameter  int DEPTH = MDU_RS_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     disp_valid_in,
  input  rs_entry_t                disp_entry_in,
  output logic                     disp_ready_out,
  input  logic                     cdb_valid_in,
  input  logic [GPR_TAG_WIDTH-1:0] cdb_tag_in,
  input  logic [XLEN-1:0]          cdb_data_in,
  input  logic                     flush_in,
  output logic                     issue_valid_out,
  output rs_entry_t                issue_entry_out,
  input  logic                     issue_ready_in,
  output logic [CNT_W-1:0]         count_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t        slot_r     [DEPTH];
  rs_entry_t        slot_nxt_s [DEPTH];
  rs_entry_t        woken_s    [DEPTH];
  rs_entry_t        disp_woken_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic [CNT_W-1:0] enq_pos_s;
  logic [DEPTH-1:0] slot_valid_s;
  logic [DEPTH-1:0] slot_ready_s;
  logic [DEPTH-1:0] pick_oh_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic             issue_fire_s;
  logic             enq_fire_s;
  logic             shift_s;

  // Valid slots are exactly those below count; ready uses registered state only.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid_s[i] = (CNT_W'(i) < count_r);
      slot_ready_s[i] = slot_valid_s[i] && slot_r[i].src1_ready && slot_r[i].src2_ready;
    end
  end

  supernova_oldest_ready_picker #(
    .DEPTH (DEPTH)
  ) u_picker (
    .ready_vec (slot_ready_s),
    .grant_oh  (pick_oh_s),
    .grant_idx (pick_idx_s),
    .any_ready (pick_any_s)
  );

  // Handshake qualifiers and next occupancy.
  always_comb begin
    disp_ready_out = (count_r < CNT_W'(DEPTH));
    enq_fire_s     = disp_valid_in && disp_ready_out;
    issue_fire_s   = pick_any_s && issue_ready_in;
    if (issue_fire_s) begin
      enq_pos_s = count_r - CNT_W'(1'b1);
    end else begin
      enq_pos_s = count_r;
    end
    case ({enq_fire_s, issue_fire_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Wake every slot, collapse above the issued slot, then drop in the new entry.
  always_comb begin
    disp_woken_s = rs_wakeup(disp_entry_in, cdb_valid_in, cdb_tag_in, cdb_data_in);
    shift_s      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      woken_s[i] = rs_wakeup(slot_r[i], cdb_valid_in, cdb_tag_in, cdb_data_in);
    end
    for (int i = 0; i < DEPTH; i++) begin
      // Once past the issued slot, every slot takes its upper neighbour.
      shift_s = shift_s | (issue_fire_s & pick_oh_s[i]);
      if (shift_s) begin
        slot_nxt_s[i] = (i < DEPTH - 1) ? woken_s[(i < DEPTH - 1) ? i + 1 : i] : '0;
      end else begin
        slot_nxt_s[i] = woken_s[i];
      end
      if (enq_fire_s && (CNT_W'(i) == enq_pos_s)) begin
        slot_nxt_s[i] = disp_woken_s;
      end else begin
        slot_nxt_s[i] = slot_nxt_s[i];
      end
    end
  end

  // Slot storage and occupancy; flush wins over everything else this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) slot_r[i] <= '0;
    end else if (flush_in) begin
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) slot_r[i] <= '0;
    end else begin
      count_r <= count_nxt_s;
      for (int i = 0; i < DEPTH; i++) slot_r[i] <= slot_nxt_s[i];
    end
  end

  // MDU request is driven straight from the selected registered slot.
  always_comb begin
    issue_valid_out = pick_any_s;
    count_out       = count_r;
    if (pick_any_s) begin
      issue_entry_out = slot_r[pick_idx_s];
    end else begin
      issue_entry_out = '0;
    end
  end

endmodule
